// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the SEQ execute stage: instruction codes,
// OPq ALU functions, jXX/cmovXX condition codes, CC bit positions and the
// condition evaluator used to form Cnd.
package y86_pkg;

  // Instruction codes (icode)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // rrmovq / cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  // ALU operations; OPq ifun 0-3 map directly onto these
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  // Condition function codes for jXX / cmovXX
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Bit positions inside cc = {ZF,SF,OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Evaluate a jXX/cmovXX condition against the given flags
  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of;
    logic res;
    zf = cc[CC_ZF];
    sf = cc[CC_SF];
    of = cc[CC_OF];
    case (ifun)
      C_YES:   res = 1'b1;
      C_LE:    res = (sf ^ of) | zf;
      C_L:     res = sf ^ of;
      C_E:     res = zf;
      C_NE:    res = ~zf;
      C_GE:    res = ~(sf ^ of);
      C_G:     res = ~(sf ^ of) & ~zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: result = b op a, plus the flags an OPq would
// load into the condition-code register.
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   op_i,
  output logic [W-1:0] result_o,
  output logic         zf_o,
  output logic         sf_o,
  output logic         of_o
);

  // Operation select and two's-complement overflow detection
  always_comb begin
    result_o = '0;
    of_o     = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o = b_i + a_i;
        of_o     = (a_i[W-1] == b_i[W-1]) && (result_o[W-1] != b_i[W-1]);
      end
      ALU_SUB: begin
        result_o = b_i - a_i;
        of_o     = (a_i[W-1] != b_i[W-1]) && (result_o[W-1] != b_i[W-1]);
      end
      ALU_AND: result_o = b_i & a_i;
      default: result_o = b_i ^ a_i;
    endcase
    zf_o = (result_o == '0);
    sf_o = result_o[W-1];
  end

endmodule

// File: rtl/seq_execute.sv
// Y86-64 SEQ execute stage: operand muxing into the ALU, the {ZF,SF,OF}
// condition-code register, Cnd evaluation and registered results.
// Optional feature macro: IADDQ_EN (makes icode C = iaddq a legal instruction).
//
// Handshake: in_valid qualifies the inputs for one cycle; there is no
// back-pressure. Each sampled in_valid produces out_valid=1 for exactly one
// cycle after the same edge; otherwise out_valid is 0 and the other results hold.
module seq_execute
  import y86_pkg::*;
#(
  parameter int         W      = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         out_valid,
  output logic [W-1:0] valE,
  output logic         Cnd,
  output logic [2:0]   cc,
  output logic         instr_err
);

  localparam logic [W-1:0] STACK_STEP = W'(8);

  logic         instr_ok;
  logic         set_cc;
  logic         is_cond;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_res;
  logic         alu_zf, alu_sf, alu_of;
  logic         cnd_d;

  logic         out_valid_q;
  logic [W-1:0] valE_q;
  logic         cnd_q;
  logic [2:0]   cc_q;
  logic         err_q;

  // Decode icode/ifun into validity, CC-write enable and ALU operand selection
  always_comb begin
    instr_ok = 1'b0;
    set_cc   = 1'b0;
    is_cond  = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = ALU_ADD;
    case (icode)
      I_HALT, I_NOP: instr_ok = (ifun == 4'h0);
      I_RRMOVQ: begin
        instr_ok = (ifun <= C_G);
        is_cond  = 1'b1;
        alu_a    = valA;
      end
      I_IRMOVQ: begin
        instr_ok = (ifun == 4'h0);
        alu_a    = valC;
      end
      I_RMMOVQ, I_MRMOVQ: begin
        instr_ok = (ifun == 4'h0);
        alu_a    = valC;
        alu_b    = valB;
      end
      I_OPQ: begin
        instr_ok = (ifun <= 4'd3);
        set_cc   = instr_ok;
        alu_a    = valA;
        alu_b    = valB;
        alu_op   = ifun[1:0];
      end
      I_JXX: begin
        instr_ok = (ifun <= C_G);
        is_cond  = 1'b1;
      end
      I_CALL, I_PUSHQ: begin
        instr_ok = (ifun == 4'h0);
        alu_a    = STACK_STEP;
        alu_b    = valB;
        alu_op   = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        instr_ok = (ifun == 4'h0);
        alu_a    = STACK_STEP;
        alu_b    = valB;
      end
`ifdef IADDQ_EN
      I_IADDQ: begin
        instr_ok = (ifun == 4'h0);
        set_cc   = instr_ok;
        alu_a    = valC;
        alu_b    = valB;
      end
`endif
      default: instr_ok = 1'b0;
    endcase
  end

  y86_alu #(.W(W)) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_res),
    .zf_o     (alu_zf),
    .sf_o     (alu_sf),
    .of_o     (alu_of)
  );

  // Cnd uses the flags held before this edge; non-conditional valid ops report 1
  always_comb begin
    cnd_d = 1'b0;
    if (instr_ok) cnd_d = is_cond ? cond_eval(cc_q, ifun) : 1'b1;
  end

  // Result and condition-code registers; invalid instructions leave cc untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      valE_q      <= '0;
      cnd_q       <= 1'b0;
      cc_q        <= CC_RST;
      err_q       <= 1'b0;
    end else if (in_valid) begin
      out_valid_q <= 1'b1;
      valE_q      <= instr_ok ? alu_res : '0;
      cnd_q       <= cnd_d;
      err_q       <= ~instr_ok;
      if (set_cc) cc_q <= {alu_zf, alu_sf, alu_of};
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign valE      = valE_q;
  assign Cnd       = cnd_q;
  assign cc        = cc_q;
  assign instr_err = err_q;

endmodule

// File: tb/tb_seq_execute.sv
// Bench for seq_execute: directed cases followed by randomized instructions,
// compared against an arithmetic reference model of the execute stage.
module tb_seq_execute;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [3:0]   icode, ifun;
  logic [W-1:0] valA, valB, valC;
  logic         out_valid;
  logic [W-1:0] valE;
  logic         Cnd;
  logic [2:0]   cc;
  logic         instr_err;

  int checks = 0;
  int errors = 0;

  // model state: last result held by the stage and current flags
  logic [W-1:0] m_valE;
  logic         m_cnd;
  logic         m_err;
  logic [2:0]   m_cc;

  seq_execute #(.W(W), .CC_RST(3'b100)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .out_valid (out_valid),
    .valE      (valE),
    .Cnd       (Cnd),
    .cc        (cc),
    .instr_err (instr_err)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // condition truth from flags, stated as signed-compare meaning
  function automatic logic ref_cond(input logic [3:0] fn, input logic [2:0] f);
    logic zf, less;
    zf   = f[2];
    less = (f[1] != f[0]);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return less || zf;
      4'd2: return less;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !less;
      4'd6: return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // reference model: one instruction, flags before -> result and flags after
  function automatic void ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] c, input logic [2:0] cc_in,
                                   output logic [W-1:0] e, output logic cnd,
                                   output logic err, output logic [2:0] cc_out);
    logic signed [W:0] wide;
    logic upd, of;
    e = '0; cnd = 1'b1; err = 1'b0; cc_out = cc_in; upd = 1'b0; of = 1'b0;
    case (ic)
      4'h0, 4'h1: err = (fn != 0);
      4'h2: begin err = (fn > 6); e = a; cnd = ref_cond(fn, cc_in); end
      4'h3: begin err = (fn != 0); e = c; end
      4'h4, 4'h5: begin err = (fn != 0); e = b + c; end
      4'h6: begin
        upd = 1'b1;
        case (fn)
          4'd0: begin wide = $signed({b[W-1], b}) + $signed({a[W-1], a}); e = wide[W-1:0]; of = wide[W] != wide[W-1]; end
          4'd1: begin wide = $signed({b[W-1], b}) - $signed({a[W-1], a}); e = wide[W-1:0]; of = wide[W] != wide[W-1]; end
          4'd2: e = b & a;
          4'd3: e = b ^ a;
          default: err = 1'b1;
        endcase
      end
      4'h7: begin err = (fn > 6); cnd = ref_cond(fn, cc_in); end
      4'h8, 4'hA: begin err = (fn != 0); e = b - 64'd8; end
      4'h9, 4'hB: begin err = (fn != 0); e = b + 64'd8; end
`ifdef IADDQ_EN
      4'hC: begin
        err = (fn != 0); upd = 1'b1;
        wide = $signed({b[W-1], b}) + $signed({c[W-1], c});
        e = wide[W-1:0]; of = wide[W] != wide[W-1];
      end
`endif
      default: err = 1'b1;
    endcase
    if (err) begin
      e = '0; cnd = 1'b0; cc_out = cc_in;
    end else if (upd) begin
      cc_out = {(e == '0), e[W-1], of};
    end
  endfunction

  task automatic model_reset();
    m_valE = '0; m_cnd = 1'b0; m_err = 1'b0; m_cc = 3'b100;
  endtask

  // driver: present one instruction for one edge, then check all outputs
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic [2:0] ncc;
    @(negedge clk);
    in_valid = 1'b1; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    ref_exec(ic, fn, a, b, c, m_cc, m_valE, m_cnd, m_err, ncc);
    m_cc = ncc;
    @(posedge clk); #1;
    chk("out_valid", W'(out_valid), W'(1'b1));
    chk("valE", valE, m_valE);
    chk("Cnd", W'(Cnd), W'(m_cnd));
    chk("instr_err", W'(instr_err), W'(m_err));
    chk("cc", W'(cc), W'(m_cc));
  endtask

  // driver: idle cycle, results must hold
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    icode = 4'($urandom_range(0, 15)); ifun = 4'($urandom_range(0, 15));
    valA = {$urandom, $urandom}; valB = {$urandom, $urandom}; valC = {$urandom, $urandom};
    @(posedge clk); #1;
    chk("idle_out_valid", W'(out_valid), '0);
    chk("idle_valE", valE, m_valE);
    chk("idle_Cnd", W'(Cnd), W'(m_cnd));
    chk("idle_err", W'(instr_err), W'(m_err));
    chk("idle_cc", W'(cc), W'(m_cc));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, W'(out_valid), '0);
    chk({tag, "_valE"}, valE, '0);
    chk({tag, "_Cnd"}, W'(Cnd), '0);
    chk({tag, "_err"}, W'(instr_err), '0);
    chk({tag, "_cc"}, W'(cc), W'(3'b100));
  endtask

  initial begin
    logic [3:0]   ric, rfn;
    logic [W-1:0] ra, rb, rc;

    // reset
    rst = 1'b1; in_valid = 1'b0; icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // subtract producing negative result, then conditions see new flags
    issue(4'h6, 4'd1, 64'd5, 64'd3, 64'd0);
    chk("sub_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_cc", W'(cc), W'(3'b010));
    issue(4'h7, 4'd2, '0, '0, 64'h40);
    chk("jl_cnd", W'(Cnd), W'(1'b1));
    issue(4'h7, 4'd3, '0, '0, 64'h40);
    chk("je_cnd", W'(Cnd), W'(1'b0));

    // signed overflow on add
    issue(4'h6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, '0);
    chk("add_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_cc", W'(cc), W'(3'b011));

    // stack pointer adjust
    issue(4'hA, 4'd0, 64'h1234, 64'h100, '0);
    chk("push_valE", valE, 64'hF8);
    chk("push_cc", W'(cc), W'(3'b011));
    issue(4'hB, 4'd0, 64'h1234, 64'h100, '0);
    chk("pop_valE", valE, 64'h108);

    // invalid instructions
    issue(4'hE, 4'd0, 64'd1, 64'd2, 64'd3);
    chk("inv_err", W'(instr_err), W'(1'b1));
    chk("inv_cc", W'(cc), W'(3'b011));
    issue(4'h6, 4'd4, 64'd1, 64'd2, 64'd3);
    issue(4'h7, 4'd7, 64'd1, 64'd2, 64'd3);
    issue(4'h1, 4'd1, 64'd1, 64'd2, 64'd3);
`ifdef IADDQ_EN
    issue(4'hC, 4'd0, '0, 64'd10, 64'hFFFF_FFFF_FFFF_FFF6);
    chk("iaddq_valE", valE, '0);
    chk("iaddq_cc", W'(cc), W'(3'b100));
`else
    issue(4'hC, 4'd0, '0, 64'd10, 64'hFFFF_FFFF_FFFF_FFF6);
    chk("iaddq_err", W'(instr_err), W'(1'b1));
`endif

    // hold across idle cycles
    issue(4'h3, 4'd0, '0, '0, 64'hDEAD_BEEF);
    repeat (3) idle();

    // asynchronous reset mid-cycle
    issue(4'h6, 4'd3, 64'h5, 64'h6, '0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_state("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // in-flight input discarded by reset held across the edge
    issue(4'h6, 4'd1, 64'd9, 64'd9, '0);
    @(negedge clk);
    in_valid = 1'b1; icode = 4'h6; ifun = 4'd1; valA = 64'd1; valB = 64'd2;
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_reset_state("inflight");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      ric = 4'($urandom_range(0, 15));
      rfn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rc  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: begin ra = W'($urandom_range(0, 9)); rb = W'($urandom_range(0, 9)); end
        2: rc = -rb;
        default: ;
      endcase
      issue(ric, rfn, ra, rb, rc);
      if ($urandom_range(0, 7) == 0) idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
